// File: rtl/null_decode_pkg.sv
// Shared definitions for the null-class decode stage: opcode map, ALU op
// codes, load-source encodings and the expansion state type.
package null_decode_pkg;

    // Null-class opcode map. Bit 3 marks a memory op, bit 2 a store,
    // bit 1 the stack space and bit 0 (on memory ops) the offset form.
    localparam logic [3:0] OPC_UJMP = 4'h0;
    localparam logic [3:0] OPC_LDSW = 4'h1;
    localparam logic [3:0] OPC_DVGA = 4'h2;
    localparam logic [3:0] OPC_SWCL = 4'h3;
    localparam logic [3:0] OPC_RMEM = 4'h8;
    localparam logic [3:0] OPC_RMOF = 4'h9;
    localparam logic [3:0] OPC_RSTK = 4'hA;
    localparam logic [3:0] OPC_RSOF = 4'hB;
    localparam logic [3:0] OPC_WMEM = 4'hC;
    localparam logic [3:0] OPC_WMOF = 4'hD;
    localparam logic [3:0] OPC_WSTK = 4'hE;
    localparam logic [3:0] OPC_WSOF = 4'hF;

    // ALU operations issued by this stage.
    localparam logic [3:0] ALU_LEFT = 4'h0;
    localparam logic [3:0] ALU_IADD = 4'h1;

    // Destination write-back source.
    localparam logic [1:0] LOAD_NONE = 2'b00;
    localparam logic [1:0] LOAD_ALU  = 2'b01;
    localparam logic [1:0] LOAD_MEM  = 2'b10;
    localparam logic [1:0] LOAD_STK  = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    // Offset memory ops (rmof/rsof/wmof/wsof) expand into two micro-ops.
    function automatic logic is_offset(input logic [3:0] opc);
        return opc[3] & opc[0];
    endfunction

endpackage

// File: rtl/null_uop_decode.sv
// Combinational decode of one null-class instruction beat into micro-op
// fields. beat=0 is the first (or only) micro-op; beat=1 is the access
// half of an offset memory op.
// Optional feature: NULL_DECODE_ILLEGAL_EN flags opcodes 0100-0111 as illegal.
module null_uop_decode
    import null_decode_pkg::*;
#(
    parameter int SEL_W = 4
) (
    input  logic [3:0]       opc,
    input  logic [SEL_W-1:0] f1,
    input  logic [SEL_W-1:0] f0,
    input  logic             beat,
    output logic [3:0]       alu_op,
    output logic [SEL_W-1:0] a_sel,
    output logic [SEL_W-1:0] b_sel,
    output logic [SEL_W-1:0] out_sel,
    output logic             a_source,
    output logic [1:0]       load_src,
    output logic             store_mem,
    output logic             store_stk,
    output logic             pc_inc,
    output logic             illegal
);

    // Scratch register carrying the computed address between beats.
    localparam logic [SEL_W-1:0] TMP_REG = {SEL_W{1'b1}};

    logic memop;
    logic store;
    logic stack;
    logic offset;

    assign memop  = opc[3];
    assign store  = opc[3] & opc[2];
    assign stack  = opc[1];
    assign offset = is_offset(opc);

    // Map opcode and fields to the micro-op for the requested beat.
    always_comb begin
        // NOTE: every output gets a default before the case logic so no
        // path leaves a signal unassigned, which would infer a latch.
        alu_op    = ALU_LEFT;
        a_sel     = '0;
        b_sel     = '0;
        out_sel   = '0;
        a_source  = 1'b0;
        load_src  = LOAD_NONE;
        store_mem = 1'b0;
        store_stk = 1'b0;
        pc_inc    = 1'b1;
        illegal   = 1'b0;

        if (memop) begin
            if (offset && !beat) begin
                // Address beat: TMP_REG <= f1 + f0.
                alu_op   = ALU_IADD;
                a_sel    = f1;
                b_sel    = f0;
                out_sel  = TMP_REG;
                load_src = LOAD_ALU;
                pc_inc   = 1'b0;
            end else begin
                // Access beat: stores swap operands so b carries the data.
                alu_op    = ALU_LEFT;
                a_sel     = store ? f0 : f1;
                b_sel     = store ? f1 : f0;
                out_sel   = store ? f1 : f0;
                load_src  = {~store, stack & ~store};
                store_mem = store & ~stack;
                store_stk = store & stack;
                if (offset) begin
                    a_sel = TMP_REG;
                end
            end
        end else if (opc == OPC_LDSW) begin
            // Switch load: ALU op comes straight from f1, operand a from switches.
            alu_op   = f1;
            a_sel    = f1;
            b_sel    = f0;
            out_sel  = f0;
            a_source = 1'b1;
            load_src = LOAD_ALU;
        end else if (opc[3:2] == 2'b01) begin
`ifdef NULL_DECODE_ILLEGAL_EN
            illegal = 1'b1;
            pc_inc  = 1'b0;
`else
            illegal = 1'b0;
`endif
        end
        // ujmp, dvga, swcl fall through as a no-op micro-op.
    end

endmodule

// File: rtl/null_decode_stage.sv
// Registered, handshaked null-instruction decode stage between fetch and
// the ALU/memory stage. One-entry output buffer; offset memory ops expand
// into an address beat followed by an access beat.
// Optional feature: NULL_DECODE_ILLEGAL_EN (see null_uop_decode).
module null_decode_stage
    import null_decode_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4+2*SEL_W-1:0] instruction,
    input  logic [DATA_W-1:0]    switches,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           uop_alu_op,
    output logic [SEL_W-1:0]     uop_a_sel,
    output logic [SEL_W-1:0]     uop_b_sel,
    output logic [SEL_W-1:0]     uop_out_sel,
    output logic                 uop_a_source,
    output logic [DATA_W-1:0]    uop_a_altern,
    output logic [1:0]           uop_load_src,
    output logic                 uop_store_mem,
    output logic                 uop_store_stk,
    output logic                 uop_pc_inc,
    output logic                 uop_illegal
);

    localparam int INST_W = 4 + 2 * SEL_W;

    state_t state;
    state_t state_next;

    // Set once the access beat of an expansion has been loaded.
    logic second_beat;

    logic [3:0]       held_opc;
    logic [SEL_W-1:0] held_f1;
    logic [SEL_W-1:0] held_f0;

    logic [3:0]       in_opc;
    logic [SEL_W-1:0] in_f1;
    logic [SEL_W-1:0] in_f0;

    logic accept;
    logic out_fire;
    logic in_expand;
    logic load_beat2;

    logic [3:0]       dec_opc;
    logic [SEL_W-1:0] dec_f1;
    logic [SEL_W-1:0] dec_f0;
    logic [3:0]       dec_alu_op;
    logic [SEL_W-1:0] dec_a_sel;
    logic [SEL_W-1:0] dec_b_sel;
    logic [SEL_W-1:0] dec_out_sel;
    logic             dec_a_source;
    logic [1:0]       dec_load_src;
    logic             dec_store_mem;
    logic             dec_store_stk;
    logic             dec_pc_inc;
    logic             dec_illegal;

    assign in_opc = instruction[INST_W-1 -: 4];
    assign in_f1  = instruction[2*SEL_W-1 -: SEL_W];
    assign in_f0  = instruction[SEL_W-1:0];

    // Ready only when idle and the output slot is free or draining this cycle.
    assign in_ready   = (state == IDLE) && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign in_expand  = (state == EXPAND);
    assign load_beat2 = in_expand && !second_beat && out_fire;

    // While expanding, the decoder works from the latched instruction.
    assign dec_opc = in_expand ? held_opc : in_opc;
    assign dec_f1  = in_expand ? held_f1  : in_f1;
    assign dec_f0  = in_expand ? held_f0  : in_f0;

    null_uop_decode #(
        .SEL_W (SEL_W)
    ) u_decode (
        .opc       (dec_opc),
        .f1        (dec_f1),
        .f0        (dec_f0),
        .beat      (in_expand),
        .alu_op    (dec_alu_op),
        .a_sel     (dec_a_sel),
        .b_sel     (dec_b_sel),
        .out_sel   (dec_out_sel),
        .a_source  (dec_a_source),
        .load_src  (dec_load_src),
        .store_mem (dec_store_mem),
        .store_stk (dec_store_stk),
        .pc_inc    (dec_pc_inc),
        .illegal   (dec_illegal)
    );

    // Expansion state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            // NOTE: state elements use non-blocking assignment so every
            // flop samples pre-edge values regardless of block ordering.
            state <= state_next;
        end
    end

    // Next state: enter EXPAND on an accepted offset op, leave when the
    // access beat is consumed or on flush.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && !flush && is_offset(in_opc)) begin
                    state_next = EXPAND;
                end
            end
            EXPAND: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (second_beat && out_fire) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output buffer, latched instruction fields and beat tracking.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid     <= 1'b0;
            second_beat   <= 1'b0;
            held_opc      <= '0;
            held_f1       <= '0;
            held_f0       <= '0;
            uop_alu_op    <= '0;
            uop_a_sel     <= '0;
            uop_b_sel     <= '0;
            uop_out_sel   <= '0;
            uop_a_source  <= 1'b0;
            uop_a_altern  <= '0;
            uop_load_src  <= LOAD_NONE;
            uop_store_mem <= 1'b0;
            uop_store_stk <= 1'b0;
            uop_pc_inc    <= 1'b0;
            uop_illegal   <= 1'b0;
        end else if (flush) begin
            // Flush wins over accept and over a simultaneous consume.
            out_valid   <= 1'b0;
            second_beat <= 1'b0;
        end else if (accept || load_beat2) begin
            out_valid     <= 1'b1;
            second_beat   <= load_beat2;
            uop_alu_op    <= dec_alu_op;
            uop_a_sel     <= dec_a_sel;
            uop_b_sel     <= dec_b_sel;
            uop_out_sel   <= dec_out_sel;
            uop_a_source  <= dec_a_source;
            uop_load_src  <= dec_load_src;
            uop_store_mem <= dec_store_mem;
            uop_store_stk <= dec_store_stk;
            uop_pc_inc    <= dec_pc_inc;
            uop_illegal   <= dec_illegal;
            if (accept) begin
                // Switches are sampled only here, never while stalled.
                uop_a_altern <= switches;
                held_opc     <= in_opc;
                held_f1      <= in_f1;
                held_f0      <= in_f0;
            end
        end else if (out_fire) begin
            out_valid   <= 1'b0;
            second_beat <= 1'b0;
        end
    end

endmodule
